// File: rtl/colhist_pkg.sv
// Shared constants, FSM encoding and counter helper for the column histogram.
package colhist_pkg;

    localparam int NUM_COLS = 80;
    localparam int COL_W    = 7;
    localparam int ROW_W    = 7;
    localparam int CNT_W    = 6;

    // Counters stop here instead of wrapping back to zero
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        START = 2'd2,
        CLEAR = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/colhist_counter_bank.sv
// Bank of per-column saturating counters with a registered read-modify-write
// port. The storage array is rewritten on every increment and is read
// directly when the next increment arrives. A pixel in the following cycle
// therefore always sees the value just written, even for the same column.
module colhist_counter_bank
    import colhist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [COL_W-1:0] col,
    input  logic             clear,
    output logic [CNT_W-1:0] rd_cnt
);

    logic [CNT_W-1:0] cnt [NUM_COLS];
    logic [CNT_W-1:0] next_cnt;

    // Saturated successor of the addressed column's current count
    always_comb begin
        next_cnt = sat_inc(cnt[col]);
    end

    // Update the addressed counter and return its new value; idle cycles return 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                cnt[i] <= '0;
            end
            rd_cnt <= '0;
        end else begin
            rd_cnt <= inc ? next_cnt : '0;
            if (clear) begin
                for (int i = 0; i < NUM_COLS; i++) begin
                    cnt[i] <= '0;
                end
            end else if (inc) begin
                cnt[col] <= next_cnt;
            end
        end
    end

endmodule

// File: rtl/column_histogram.sv
// Per-column histogram of colour-matched pixels for one frame. The design
// emits (column, count) pairs as follows: the column appears one cycle after
// the pixel, and the count appears one cycle after the column. At frame end
// it drains, pulses start, and clears.
// Define COLHIST_ROI_EN to count only rows ROW_MIN..ROW_MAX.
module column_histogram
    import colhist_pkg::*;
#(
    parameter int ROW_MIN = 0,
    parameter int ROW_MAX = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             px_valid,
    input  logic             px_match,
    input  logic [COL_W-1:0] px_col,
    input  logic [ROW_W-1:0] px_row,
    input  logic             frame_end,
    output logic [COL_W-1:0] px_pos_ret,
    output logic [CNT_W-1:0] reg_histograma,
    output logic             start,
    output logic             busy
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    state_t           state;
    logic             flush_cnt;
    logic             row_ok;
    logic             accept;
    logic [CNT_W-1:0] rd_cnt;

`ifdef COLHIST_ROI_EN
    // Restrict counting to the configured row window
    always_comb begin
        row_ok = (int'(px_row) >= ROW_MIN) && (int'(px_row) <= ROW_MAX);
    end
`else
    logic unused_row;
    assign unused_row = ^{px_row, ROW_MIN[0], ROW_MAX[0]};

    // Without the row window every row counts
    always_comb begin
        row_ok = 1'b1;
    end
`endif

    // A pixel counts only while accumulating and when it is a valid in-range match
    always_comb begin
        accept = (state == ACCUM) && px_valid && px_match &&
                 (px_col <= LAST_COL) && row_ok;
    end

    colhist_counter_bank u_bank (
        .clk    (clk),
        .rst    (rst),
        .inc    (accept),
        .col    (px_col),
        .clear  (state == CLEAR),
        .rd_cnt (rd_cnt)
    );

    // Frame sequencing: two drain cycles, a one-cycle start pulse, then a clear cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            flush_cnt <= 1'b0;
            start     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (frame_end) begin
                        state     <= FLUSH;
                        flush_cnt <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt) begin
                        state <= START;
                        start <= 1'b1;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                START: begin
                    state <= CLEAR;
                    start <= 1'b0;
                end
                CLEAR: begin
                    state <= ACCUM;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ACCUM;
                    start <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output stage: the column follows the accepted pixel, and the count follows one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_pos_ret     <= '0;
            reg_histograma <= '0;
        end else begin
            reg_histograma <= rd_cnt;
            if (accept) begin
                px_pos_ret <= px_col;
            end
        end
    end

endmodule

// File: tb/tb_column_histogram.sv
// Self-checking bench for column_histogram: a cycle-scheduled reference model
// plus directed vectors with hand-computed expectations.
module tb_column_histogram;

    localparam int DEPTH = 1024;

    logic       clk;
    logic       rst;
    logic       px_valid;
    logic       px_match;
    logic [6:0] px_col;
    logic [6:0] px_row;
    logic       frame_end;
    logic [6:0] px_pos_ret;
    logic [5:0] reg_histograma;
    logic       start;
    logic       busy;

    int n_vec  = 0;
    int n_fail = 0;

    column_histogram dut (
        .clk            (clk),
        .rst            (rst),
        .px_valid       (px_valid),
        .px_match       (px_match),
        .px_col         (px_col),
        .px_row         (px_row),
        .frame_end      (frame_end),
        .px_pos_ret     (px_pos_ret),
        .reg_histograma (reg_histograma),
        .start          (start),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs, indexed by cycle number (a cycle starts at a rising edge)
    int         cyc = 0;
    int         fe_cyc = -100;
    int         cnt_m [80];
    logic [6:0] e_pos   [DEPTH];
    logic [5:0] e_hist  [DEPTH];
    bit         e_start [DEPTH];
    bit         e_busy  [DEPTH];

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit m, input int col, input int row, input bit fe);
        @(negedge clk);
        px_valid  = v;
        px_match  = m;
        px_col    = 7'(col);
        px_row    = 7'(row);
        frame_end = fe;
    endtask

    // Reference model: consumes the inputs of the cycle that just ended
    always @(posedge clk) begin
        int  p;
        int  nc;
        bit  in_accum;
        bit  acc;
        bit  roi_ok;
        p   = cyc;
        cyc = cyc + 1;
        if (cyc + 1 < DEPTH) begin
            if (rst) begin
                fe_cyc = -100;
                for (int i = 0; i < 80; i++) cnt_m[i] = 0;
                e_pos[cyc]   = 0;
                e_hist[cyc]  = 0;
                e_hist[cyc+1] = 0;
                e_start[cyc] = 0;
                e_busy[cyc]  = 0;
            end else begin
                in_accum = !(p >= fe_cyc + 1 && p <= fe_cyc + 4);
                if (p == fe_cyc + 4) begin
                    for (int i = 0; i < 80; i++) cnt_m[i] = 0;
                end
`ifdef COLHIST_ROI_EN
                roi_ok = (px_row <= 7'd59);
`else
                roi_ok = 1'b1;
`endif
                acc = in_accum && px_valid && px_match && (px_col < 7'd80) && roi_ok;
                if (acc) begin
                    nc = cnt_m[px_col] + 1;
                    if (nc > 63) nc = 63;
                    cnt_m[px_col] = nc;
                    e_pos[cyc]    = px_col;
                    e_hist[cyc+1] = 6'(nc);
                end else begin
                    e_pos[cyc]    = e_pos[p];
                    e_hist[cyc+1] = 0;
                end
                if (in_accum && frame_end) fe_cyc = p;
                e_busy[cyc]  = (cyc >= fe_cyc + 1) && (cyc <= fe_cyc + 4);
                e_start[cyc] = (cyc == fe_cyc + 3);
            end
        end
    end

    // Compare every output against the model in the middle of each cycle
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (cyc >= 1 && cyc < DEPTH) begin
                checkOutput("px_pos_ret",     px_pos_ret,     e_pos[cyc]);
                checkOutput("reg_histograma", reg_histograma, e_hist[cyc]);
                checkOutput("start",          start,          e_start[cyc]);
                checkOutput("busy",           busy,           e_busy[cyc]);
            end
        end
    end

    // Directed stimulus with literal expectations
    initial begin
        rst = 1'b1; px_valid = 0; px_match = 0; px_col = 0; px_row = 0; frame_end = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #3;
        checkOutput("lit_reset_pos",   px_pos_ret,     0);
        checkOutput("lit_reset_hist",  reg_histograma, 0);
        checkOutput("lit_reset_start", start,          0);
        checkOutput("lit_reset_busy",  busy,           0);

        // Five matches at column 10: counts 1..5 two cycles after each pixel
        for (int i = 0; i < 7; i++) begin
            if (i < 5) applyStimulus(1, 1, 10, 0, 0);
            else       applyStimulus(0, 0, 0, 0, 0);
            @(posedge clk); #3;
            checkOutput("lit_col10_hist", reg_histograma, (i >= 1 && i <= 5) ? i : 0);
            checkOutput("lit_col10_pos",  px_pos_ret, 10);
        end

        // Seventy matches at column 3: saturate at 63
        for (int i = 0; i < 72; i++) begin
            if (i < 70) applyStimulus(1, 1, 3, 0, 0);
            else        applyStimulus(0, 0, 0, 0, 0);
            @(posedge clk); #3;
            if (i == 62) checkOutput("lit_sat_62", reg_histograma, 62);
            if (i == 70) checkOutput("lit_sat_63", reg_histograma, 63);
            if (i == 71) checkOutput("lit_sat_idle", reg_histograma, 0);
        end

        // Rejected pixels: out-of-range column, no match, not valid
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       applyStimulus(1, 1, 80, 0, 0);
                1:       applyStimulus(1, 0, 3, 0, 0);
                2:       applyStimulus(0, 1, 3, 0, 0);
                default: applyStimulus(0, 0, 0, 0, 0);
            endcase
            @(posedge clk); #3;
            checkOutput("lit_reject_hist", reg_histograma, 0);
            checkOutput("lit_reject_pos",  px_pos_ret, 3);
        end

        // Last pixel at column 79 together with frame_end
        applyStimulus(1, 1, 79, 0, 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #3;
            checkOutput("lit_fe_start", start, (i == 2) ? 1 : 0);
            checkOutput("lit_fe_busy",  busy,  (i <= 3) ? 1 : 0);
            checkOutput("lit_fe_hist",  reg_histograma, (i == 1) ? 1 : 0);
            if (i == 0)      applyStimulus(1, 1, 5, 0, 0);
            else if (i == 1) applyStimulus(0, 0, 0, 0, 1);
            else             applyStimulus(0, 0, 0, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0);

        // Next frame starts from cleared counters
        applyStimulus(1, 1, 79, 0, 0);
        @(posedge clk); #3;
        applyStimulus(1, 1, 10, 0, 0);
        @(posedge clk); #3;
        checkOutput("lit_newframe_79", reg_histograma, 1);
        applyStimulus(0, 0, 0, 0, 0);
        @(posedge clk); #3;
        checkOutput("lit_newframe_10", reg_histograma, 1);
        checkOutput("lit_newframe_pos", px_pos_ret, 10);

        // Row window: row 60 then row 59 at column 20
        applyStimulus(1, 1, 20, 60, 0);
        @(posedge clk); #3;
        applyStimulus(1, 1, 20, 59, 0);
        @(posedge clk); #3;
`ifdef COLHIST_ROI_EN
        checkOutput("lit_row60", reg_histograma, 0);
`else
        checkOutput("lit_row60", reg_histograma, 1);
`endif
        applyStimulus(0, 0, 0, 0, 0);
        @(posedge clk); #3;
`ifdef COLHIST_ROI_EN
        checkOutput("lit_row59", reg_histograma, 1);
`else
        checkOutput("lit_row59", reg_histograma, 2);
`endif

        // Reset while flushing: outputs clear at once and no start follows
        applyStimulus(1, 1, 30, 0, 1);
        @(posedge clk); #3;
        checkOutput("lit_flush_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1; px_valid = 0; px_match = 0; frame_end = 0;
        @(posedge clk); #3;
        checkOutput("lit_rstflush_hist", reg_histograma, 0);
        checkOutput("lit_rstflush_pos",  px_pos_ret, 0);
        checkOutput("lit_rstflush_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            @(posedge clk); #3;
            checkOutput("lit_rstflush_start", start, 0);
        end
        applyStimulus(1, 1, 30, 0, 0);
        @(posedge clk); #3;
        applyStimulus(0, 0, 0, 0, 0);
        @(posedge clk); #3;
        checkOutput("lit_after_rst_30", reg_histograma, 1);

        repeat (4) applyStimulus(0, 0, 0, 0, 0);
        @(posedge clk); #4;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
